// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, the
// HI/LO result pair and the single-shot arithmetic used to fill pend_hi/pend_lo.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // Divide by zero falls through to the current HI/LO so the later commit is a no-op.
  function automatic md_result_t md_compute(input md_op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi_cur,
                                            input logic [31:0] lo_cur);
    md_result_t r;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        is_signed;
    r.hi      = hi_cur;
    r.lo      = lo_cur;
    is_signed = (op == MD_DIV);
    mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    quot      = mag_a / mag_b;
    rem       = mag_a % mag_b;
    prod      = '0;
    case (op)
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          r.lo = (is_signed && (a[31] ^ b[31])) ? (~quot + 32'd1) : quot;
          r.hi = (is_signed && a[31]) ? (~rem + 32'd1) : rem;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage operand/result bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output md_op, A, B, input start, busy, hi, lo);
  modport slave  (input md_op, A, B, output start, busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed at the start edge
// and held in pend_hi/pend_lo; a countdown models the MIPS latency before commit.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e      op;
  logic        is_start_op;
  logic        is_mult_op;
  logic        busy;
  md_result_t  result;
  logic [CNT_W-1:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  assign op          = md_op_e'(md.md_op);
  assign is_mult_op  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_start_op = is_mult_op || (op == MD_DIV) || (op == MD_DIVU);
  assign busy        = (cnt != '0);

  assign md.busy  = busy;
  assign md.start = is_start_op && !busy;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

  always_comb begin
    result = md_compute(op, md.A, md.B, hi_q, lo_q);
  end

  // While counting, every md_op is ignored; HI/LO change only on the 1->0 step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (is_start_op) begin
      pend_hi <= result.hi;
      pend_lo <= result.lo;
      cnt     <= is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (op == MD_MTHI) begin
      hi_q <= md.A;
    end else if (op == MD_MTLO) begin
      lo_q <= md.A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized traffic
// compared against a cycle-count reference model of HI/LO and the busy window.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: absolute edge count, edge at which the busy window ends,
  // and the result waiting to land at that edge.
  int unsigned cyc = 0;
  int unsigned busy_end = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_phi = '0;
  logic [31:0] m_plo = '0;
  bit          m_pend_ok = 1'b0;

  function automatic bit op_is_start(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic bit model_busy();
    return cyc < busy_end;
  endfunction

  function automatic void ref_compute(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rh,
                                      output logic [31:0] rl, output bit ok);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    ok = 1'b1;
    rh = '0;
    rl = '0;
    if (op == 4'd1) begin
      sp = longint'(sa) * longint'(sb);
      up = sp;
      rh = up[63:32];
      rl = up[31:0];
    end else if (op == 4'd2) begin
      up = 64'(a) * 64'(b);
      rh = up[63:32];
      rl = up[31:0];
    end else if (b == 32'd0) begin
      ok = 1'b0;
    end else if (op == 4'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        rl = 32'h8000_0000;
        rh = 32'd0;
      end else begin
        rl = sa / sb;
        rh = sa % sb;
      end
    end else begin
      rl = a / b;
      rh = a % b;
    end
  endfunction

  function automatic void model_edge();
    bit was_busy;
    was_busy = model_busy();
    cyc++;
    if (reset) begin
      m_hi      = '0;
      m_lo      = '0;
      m_pend_ok = 1'b0;
      busy_end  = cyc;
    end else if (was_busy) begin
      if (cyc == busy_end && m_pend_ok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (op_is_start(bus.md_op)) begin
      ref_compute(bus.md_op, bus.A, bus.B, m_phi, m_plo, m_pend_ok);
      busy_end = cyc + ((bus.md_op <= 4'd2) ? 5 : 10);
    end else if (bus.md_op == MD_MTHI) begin
      m_hi = bus.A;
    end else if (bus.md_op == MD_MTLO) begin
      m_lo = bus.A;
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_op = op;
    bus.A     = a;
    bus.B     = b;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
    bus.md_op = MD_NONE;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(MD_MULT, 32'd5, 32'd3);
    advance();
    advance();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    else n_pass++;
    reset = 1'b0;
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    advance();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.start !== 1'b0)
      $display("[TB] FAIL reset_idle: busy=%b start=%b, required 0/0", bus.busy, bus.start);
    else n_pass++;
  endtask

  // Starts one operation and follows it through its whole busy window.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    applyStimulus(op, a, b);
    n_checks++;
    if (bus.start !== 1'b1)
      $display("[TB] FAIL %s_start: start=%b, required 1", name, bus.start);
    else n_pass++;
    advance();
    for (int c = 1; c <= n; c++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.hi !== old_hi || bus.lo !== old_lo)
        $display("[TB] FAIL %s_busy_c%0d: busy=%b hi=%h lo=%h, required busy=1 hi=%h lo=%h",
                 name, c, bus.busy, bus.hi, bus.lo, old_hi, old_lo);
      else n_pass++;
      applyStimulus(MD_NONE, 32'd0, 32'd0);
      advance();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== eh || bus.lo !== el)
      $display("[TB] FAIL %s_result: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
               name, bus.busy, bus.hi, bus.lo, eh, el);
    else n_pass++;
  endtask

  task automatic test_mult();
    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
  endtask

  task automatic test_multu();
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
  endtask

  task automatic test_div_zero();
    applyStimulus(MD_MTHI, 32'h11, 32'd0);
    advance();
    applyStimulus(MD_MTLO, 32'h22, 32'd0);
    n_checks++;
    if (bus.hi !== 32'h11 || bus.busy !== 1'b0)
      $display("[TB] FAIL mthi: hi=%h busy=%b, required hi=00000011 busy=0", bus.hi, bus.busy);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.lo !== 32'h22 || bus.busy !== 1'b0)
      $display("[TB] FAIL mtlo: lo=%h busy=%b, required lo=00000022 busy=0", bus.lo, bus.busy);
    else n_pass++;
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_ignore_while_busy();
    applyStimulus(MD_MULT, 32'h1234_5678, 32'h100);
    advance();
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) applyStimulus(MD_MTLO, 32'h55, 32'd0);
      else if (c == 3) applyStimulus(MD_DIV, 32'd100, 32'd3);
      else applyStimulus(MD_NONE, 32'd0, 32'd0);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.start !== 1'b0)
        $display("[TB] FAIL ignore_busy_c%0d: busy=%b start=%b, required busy=1 start=0", c, bus.busy, bus.start);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h12 || bus.lo !== 32'h3456_7800)
      $display("[TB] FAIL ignore_result: busy=%b hi=%h lo=%h, required busy=0 hi=00000012 lo=34567800",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
    applyStimulus(MD_MTLO, 32'h55, 32'd0);
    advance();
    n_checks++;
    if (bus.lo !== 32'h55 || bus.hi !== 32'h12)
      $display("[TB] FAIL mtlo_after: hi=%h lo=%h, required hi=00000012 lo=00000055", bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    applyStimulus(MD_DIV, 32'd100, 32'd7);
    advance();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(MD_NONE, 32'd0, 32'd0);
      advance();
    end
    reset = 1'b1;
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    advance();
    reset = 1'b0;
    for (int c = 5; c <= 16; c++) begin
      n_checks++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
        $display("[TB] FAIL reset_mid_c%0d: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0",
                 c, bus.busy, bus.hi, bus.lo);
      else n_pass++;
      applyStimulus(MD_NONE, 32'd0, 32'd0);
      advance();
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    bit          exp_start;
    for (int i = 0; i < 400; i++) begin
      op  = 4'($urandom_range(0, 8));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 7));
      else if (sel == 3) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus(op, a, b);
      exp_start = op_is_start(op) && !model_busy();
      n_checks++;
      if (bus.start !== exp_start)
        $display("[TB] FAIL rand_start_%0d: start=%b, required %b (op=%0d)", i, bus.start, exp_start, op);
      else n_pass++;
      advance();
      reset = 1'b0;
      n_checks++;
      if (bus.busy !== model_busy() || bus.hi !== m_hi || bus.lo !== m_lo)
        $display("[TB] FAIL rand_state_%0d: busy=%b hi=%h lo=%h, required busy=%b hi=%h lo=%h",
                 i, bus.busy, bus.hi, bus.lo, model_busy(), m_hi, m_lo);
      else n_pass++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.md_op = MD_NONE;
    bus.A     = '0;
    bus.B     = '0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO registers.
- Sits in the E stage. It consumes the forwarded rs/rt operands (the same values that feed the ALU) and reports busy to the stall unit.
- It supplies HI/LO to the E-stage result mux for mfhi/mflo.
- It models MIPS mult/multu/div/divu latency with a countdown rather than a real iterative datapath.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- md_op  input  4  E-stage operation code; `MD_NONE` = idle; valid for exactly one cycle per E-stage instruction.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- start  output  1  combinational; high when md_op is MULT/MULTU/DIV/DIVU and the unit is not busy.
- busy  output  1  registered; high while a computation is in flight.
- hi  output  32  current HI register, combinational read.
- lo  output  32  current LO register, combinational read.

Behaviour:
- **Reset** (sync, takes priority over everything):
  - hi=0, lo=0, busy=0, counter=0.
  - Pending result registers cleared.
  - Any in-flight operation is discarded.
- **State:** 4-bit counter `cnt`; busy = (cnt != 0). Plus 32-bit pend_hi and pend_lo.
- **Start, edge T with start=1:**
  - Compute the result from A/B at that edge and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - busy is high in cycles T+1 .. T+N.
- **Countdown:** while cnt != 0, cnt decrements every cycle.
- **Commit:** on the edge where cnt goes 1→0, hi←pend_hi and lo←pend_lo.
  - The new HI/LO is visible in the first cycle with busy=0.
  - Before commit, hi/lo still show the old values.
- **Arithmetic:**
  - MULT: signed 64-bit product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 64-bit product; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder, taking the dividend's sign.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (B=0, DIV or DIVU): the busy period runs normally, but commit leaves hi/lo unchanged.
- **MTHI / MTLO:**
  - Only when busy=0: write A into hi (MTHI) or lo (MTLO) at the edge. Visible the next cycle, no busy.
  - When busy=1: ignored.
- **md_op while busy=1:**
  - Start ops and MTHI/MTLO are ignored, with no state change.
  - The stall unit guarantees this never happens: it stalls any md-class instruction (mult/div/mfhi/mflo/mthi/mtlo) in D while (busy || start).
- **Counter width:** must hold max(MULT_CYCLES, DIV_CYCLES); a value of 0 for either parameter is illegal.
- **No back-to-back overlap:** the next start may be accepted no earlier than the first cycle with busy=0.

Decomposition:
- constant.v gains `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6, `MD_MFHI`=7, `MD_MFLO`=8.
- The E-stage CU decodes these codes. md_unit treats MFHI/MFLO as no-ops; the E result mux selects hi/lo for them.
- The SU gains inputs busy and start.
- No sub-module: the arithmetic is a single combinational block feeding the pend registers.

Test Plan:
- Reset, then md_op=MULT, A=0xFFFFFFFF, B=2 at cycle 0:
  - busy=1 for cycles 1-5, hi/lo still 0 during cycles 1-5.
  - Cycle 6: busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with A=0xFFFFFFFF, B=2:
  - After 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV with A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU with A=7, B=0, after hi=0x11, lo=0x22 were set via MTHI/MTLO:
  - busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
  - Also check DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- MULT start, then at cycle 2 apply md_op=MTLO with A=0x55 and md_op=DIV:
  - Both are ignored; after cycle 6, lo equals the MULT result.
  - A further MTLO with A=0x55 at cycle 6 yields lo=0x55 at cycle 7.
- DIV started, then reset asserted at cycle 4:
  - Cycle 5: busy=0, hi=lo=0; no commit occurs later.
